// File: rtl/cgia_pkg.sv
// Shared CGIA definitions: grant encoding and video memory bus widths.
package cgia_pkg;

  localparam int ADR_W = 23;
  localparam int DAT_W = 16;

  typedef enum logic [1:0] {
    GNT_NONE  = 2'b00,
    GNT_FETCH = 2'b01,
    GNT_CPU   = 2'b10
  } gnt_t;

endpackage

// File: rtl/vidmem_arbiter_if.sv
// Bus bundle for vidmem_arbiter: fetcher port, CPU port, memory-controller port and grant.
// Handshake: Wishbone classic; a request is held with CYC/STB high and completes on the cycle ACK (or ERR) is high.
interface vidmem_arbiter_if;
   import cgia_pkg::*;

   logic             f_cyc_i;
   logic [ADR_W-1:0] f_adr_i;
   logic             f_ack_o;
   logic             f_err_o;

   logic             c_cyc_i;
   logic             c_stb_i;
   logic             c_we_i;
   logic [1:0]       c_sel_i;
   logic [ADR_W-1:0] c_adr_i;
   logic [DAT_W-1:0] c_dat_i;
   logic [DAT_W-1:0] c_dat_o;
   logic             c_ack_o;
   logic             c_err_o;

   logic             m_cyc_o;
   logic             m_stb_o;
   logic             m_we_o;
   logic [1:0]       m_sel_o;
   logic [ADR_W-1:0] m_adr_o;
   logic [DAT_W-1:0] m_dat_o;
   logic [DAT_W-1:0] m_dat_i;
   logic             m_ack_i;

   logic [1:0]       gnt_o;

   // Arbiter view.
   modport slave (
      input  f_cyc_i, f_adr_i, c_cyc_i, c_stb_i, c_we_i, c_sel_i, c_adr_i, c_dat_i,
      input  m_dat_i, m_ack_i,
      output f_ack_o, f_err_o, c_dat_o, c_ack_o, c_err_o,
      output m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o, m_dat_o, gnt_o
   );

   // Requesters and memory controller view.
   modport master (
      output f_cyc_i, f_adr_i, c_cyc_i, c_stb_i, c_we_i, c_sel_i, c_adr_i, c_dat_i,
      output m_dat_i, m_ack_i,
      input  f_ack_o, f_err_o, c_dat_o, c_ack_o, c_err_o,
      input  m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o, m_dat_o, gnt_o
   );

endinterface

// File: rtl/vmarb_timeout.sv
// Stall watchdog: counts consecutive un-ACKed strobe cycles and flags expiry at TIMEOUT.
module vmarb_timeout #(
   parameter int TIMEOUT = 255
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic stb,
   input  logic ack,
   input  logic clr,
   output logic expire
);

   localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

   logic [7:0] cnt_q;

   // Expiry is the TIMEOUT-th stalled cycle, i.e. TIMEOUT-1 stalls already counted.
   assign expire = stb && (cnt_q == LIMIT);

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         cnt_q <= 8'd0;
      end else if (!stb || ack || clr || expire) begin
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_q + 8'd1;
      end
   end

endmodule

// File: rtl/vidmem_arbiter.sv
// Two-master Wishbone arbiter: CGIA fetcher (priority) and CPU share one memory port.
// Optional stall timeout enabled with macro VMARB_TIMEOUT_EN.
module vidmem_arbiter
   import cgia_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic             clk_i,
   input  logic             reset_i,
   vidmem_arbiter_if.slave  bus
);

   gnt_t gnt_q;
   gnt_t gnt_d;
   logic owner_cyc;
   logic expire;
   logic ack_ok;

   always_comb begin
      owner_cyc = 1'b0;
      case (gnt_q)
         GNT_FETCH: owner_cyc = bus.f_cyc_i;
         GNT_CPU:   owner_cyc = bus.c_cyc_i;
         default:   owner_cyc = 1'b0;
      endcase

      // Owner keeps the bus while its CYC is high; release hands over on the same edge.
      gnt_d = gnt_q;
      if (expire) begin
         gnt_d = GNT_NONE;
      end else if (gnt_q == GNT_NONE || !owner_cyc) begin
         if (bus.f_cyc_i)      gnt_d = GNT_FETCH;
         else if (bus.c_cyc_i) gnt_d = GNT_CPU;
         else                  gnt_d = GNT_NONE;
      end
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         gnt_q <= GNT_NONE;
      end else begin
         gnt_q <= gnt_d;
      end
   end

   assign bus.gnt_o = gnt_q;

   always_comb begin
      bus.m_cyc_o = 1'b0;
      bus.m_stb_o = 1'b0;
      bus.m_we_o  = 1'b0;
      bus.m_sel_o = 2'b00;
      bus.m_adr_o = '0;
      bus.m_dat_o = '0;
      case (gnt_q)
         GNT_FETCH: begin
            bus.m_cyc_o = bus.f_cyc_i;
            bus.m_stb_o = bus.f_cyc_i;
            bus.m_sel_o = 2'b11;
            bus.m_adr_o = bus.f_adr_i;
         end
         GNT_CPU: begin
            bus.m_cyc_o = bus.c_cyc_i;
            bus.m_stb_o = bus.c_stb_i;
            bus.m_we_o  = bus.c_we_i;
            bus.m_sel_o = bus.c_sel_i;
            bus.m_adr_o = bus.c_adr_i;
            bus.m_dat_o = bus.c_dat_i;
         end
         default: ;
      endcase
   end

   // A late ACK in the expiry cycle is dropped; the transfer is reported as an error instead.
   assign ack_ok      = bus.m_ack_i && !expire;
   assign bus.f_ack_o = ack_ok && (gnt_q == GNT_FETCH);
   assign bus.c_ack_o = ack_ok && (gnt_q == GNT_CPU);
   assign bus.c_dat_o = bus.m_dat_i;

`ifdef VMARB_TIMEOUT_EN
   logic gnt_chg;
   assign gnt_chg = (gnt_d != gnt_q);

   vmarb_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .stb     (bus.m_stb_o),
      .ack     (bus.m_ack_i),
      .clr     (gnt_chg),
      .expire  (expire)
   );

   assign bus.f_err_o = expire && (gnt_q == GNT_FETCH);
   assign bus.c_err_o = expire && (gnt_q == GNT_CPU);
`else
   logic unused_timeout;
   assign unused_timeout = ^8'(TIMEOUT);
   assign expire      = 1'b0;
   assign bus.f_err_o = 1'b0;
   assign bus.c_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_vidmem_arbiter.sv
// Directed bench for vidmem_arbiter: reset, priority, no preemption, handoff, timeout, async reset.
module tb_vidmem_arbiter;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

`ifdef VMARB_TIMEOUT_EN
   localparam int TB_TIMEOUT = 4;
`else
   localparam int TB_TIMEOUT = 255;
`endif

   vidmem_arbiter_if bus ();

   vidmem_arbiter #(
      .TIMEOUT (TB_TIMEOUT)
   ) dut (
      .clk_i   (clk),
      .reset_i (rst_n),
      .bus     (bus)
   );

   // Clock/reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.f_cyc_i = 1'b0;
      bus.f_adr_i = '0;
      bus.c_cyc_i = 1'b0;
      bus.c_stb_i = 1'b0;
      bus.c_we_i  = 1'b0;
      bus.c_sel_i = 2'b00;
      bus.c_adr_i = '0;
      bus.c_dat_i = '0;
      bus.m_dat_i = '0;
      bus.m_ack_i = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      idle_inputs();
      bus.m_ack_i = 1'b1;
      tick();
      tick();

      // Reset then idle
      chk("rst_gnt",   32'(bus.gnt_o),   32'h0);
      chk("rst_mcyc",  32'(bus.m_cyc_o), 32'h0);
      chk("rst_fack",  32'(bus.f_ack_o), 32'h0);
      chk("rst_cack",  32'(bus.c_ack_o), 32'h0);
      chk("rst_ferr",  32'(bus.f_err_o), 32'h0);
      chk("rst_cerr",  32'(bus.c_err_o), 32'h0);
      rst_n = 1'b1;
      bus.m_ack_i = 1'b0;
      tick();
      chk("idle_gnt",  32'(bus.gnt_o),   32'h0);
      chk("idle_mcyc", 32'(bus.m_cyc_o), 32'h0);

      // Simultaneous request: fetcher wins
      bus.f_cyc_i = 1'b1;
      bus.f_adr_i = 23'h7F8000;
      bus.c_cyc_i = 1'b1;
      bus.c_stb_i = 1'b1;
      bus.c_we_i  = 1'b1;
      bus.c_sel_i = 2'b01;
      bus.c_adr_i = 23'h000100;
      bus.c_dat_i = 16'hA5A5;
      #1;
      chk("sim_pre_gnt",  32'(bus.gnt_o),   32'h0);
      chk("sim_pre_mcyc", 32'(bus.m_cyc_o), 32'h0);
      tick();
      chk("sim_gnt",  32'(bus.gnt_o),   32'h1);
      chk("sim_madr", 32'(bus.m_adr_o), 32'h7F8000);
      chk("sim_mcyc", 32'(bus.m_cyc_o), 32'h1);
      chk("sim_mstb", 32'(bus.m_stb_o), 32'h1);
      chk("sim_mwe",  32'(bus.m_we_o),  32'h0);
      chk("sim_msel", 32'(bus.m_sel_o), 32'h3);
      chk("sim_mdat", 32'(bus.m_dat_o), 32'h0);
      bus.m_ack_i = 1'b1;
      #1;
      chk("sim_fack", 32'(bus.f_ack_o), 32'h1);
      chk("sim_cack", 32'(bus.c_ack_o), 32'h0);

      // Fetcher releases, CPU takes over on the same edge
      bus.f_cyc_i = 1'b0;
      bus.m_ack_i = 1'b0;
      tick();
      chk("cpu_gnt",  32'(bus.gnt_o),   32'h2);
      chk("cpu_madr", 32'(bus.m_adr_o), 32'h000100);
      chk("cpu_mwe",  32'(bus.m_we_o),  32'h1);
      chk("cpu_msel", 32'(bus.m_sel_o), 32'h1);
      chk("cpu_mdat", 32'(bus.m_dat_o), 32'hA5A5);

      // No preemption across 3 wait states
      bus.f_cyc_i = 1'b1;
      bus.f_adr_i = 23'h010000;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("np_cack", 32'(bus.c_ack_o), 32'h0);
         chk("np_fack", 32'(bus.f_ack_o), 32'h0);
         tick();
         chk("np_gnt",  32'(bus.gnt_o),   32'h2);
      end
      bus.m_ack_i = 1'b1;
      #1;
      chk("np_cack_done", 32'(bus.c_ack_o), 32'h1);
      chk("np_fack_done", 32'(bus.f_ack_o), 32'h0);
      tick();
      chk("np_gnt_hold", 32'(bus.gnt_o), 32'h2);
      bus.c_cyc_i = 1'b0;
      bus.c_stb_i = 1'b0;
      bus.m_ack_i = 1'b0;
      tick();
      chk("np_gnt_fetch", 32'(bus.gnt_o), 32'h1);

      // Handoff: 6-word fetch burst with CPU pending
      bus.c_cyc_i = 1'b1;
      bus.c_stb_i = 1'b1;
      bus.c_we_i  = 1'b0;
      bus.c_sel_i = 2'b11;
      bus.c_adr_i = 23'h000200;
      for (int i = 0; i < 6; i++) begin
         bus.f_adr_i = 23'h010000 + 23'(i);
         bus.m_ack_i = 1'b1;
         #1;
         chk("ho_fack", 32'(bus.f_ack_o), 32'h1);
         chk("ho_cack", 32'(bus.c_ack_o), 32'h0);
         chk("ho_madr", 32'(bus.m_adr_o), 32'h010000 + 32'(i));
         tick();
         chk("ho_gnt",  32'(bus.gnt_o),   32'h1);
      end
      bus.f_cyc_i = 1'b0;
      bus.m_ack_i = 1'b0;
      #1;
      chk("ho_rel_mcyc", 32'(bus.m_cyc_o), 32'h0);
      tick();
      chk("ho_gnt_cpu",  32'(bus.gnt_o),   32'h2);
      chk("ho_mcyc_cpu", 32'(bus.m_cyc_o), 32'h1);
      chk("ho_madr_cpu", 32'(bus.m_adr_o), 32'h000200);
      bus.m_dat_i = 16'hBEEF;
      bus.m_ack_i = 1'b1;
      #1;
      chk("rd_cack", 32'(bus.c_ack_o), 32'h1);
      chk("rd_cdat", 32'(bus.c_dat_o), 32'hBEEF);
      chk("rd_fack", 32'(bus.f_ack_o), 32'h0);
      tick();
      bus.c_cyc_i = 1'b0;
      bus.c_stb_i = 1'b0;
      bus.m_ack_i = 1'b0;
      tick();
      chk("rd_gnt_idle", 32'(bus.gnt_o), 32'h0);

`ifdef VMARB_TIMEOUT_EN
      // Timeout: slave never ACKs the CPU
      bus.c_cyc_i = 1'b1;
      bus.c_stb_i = 1'b1;
      tick();
      chk("to_gnt", 32'(bus.gnt_o), 32'h2);
      for (int i = 0; i < 3; i++) begin
         chk("to_cerr_early", 32'(bus.c_err_o), 32'h0);
         tick();
         chk("to_gnt_hold", 32'(bus.gnt_o), 32'h2);
      end
      bus.m_ack_i = 1'b1;
      #1;
      chk("to_cerr", 32'(bus.c_err_o), 32'h1);
      chk("to_ferr", 32'(bus.f_err_o), 32'h0);
      chk("to_late_ack", 32'(bus.c_ack_o), 32'h0);
      tick();
      bus.m_ack_i = 1'b0;
      #1;
      chk("to_gnt_none", 32'(bus.gnt_o), 32'h0);
      chk("to_cerr_off", 32'(bus.c_err_o), 32'h0);
      tick();
      chk("to_regrant", 32'(bus.gnt_o), 32'h2);
      bus.c_cyc_i = 1'b0;
      bus.c_stb_i = 1'b0;
      tick();
      chk("to_idle", 32'(bus.gnt_o), 32'h0);
`endif

      // Async reset mid-burst
      bus.f_cyc_i = 1'b1;
      bus.f_adr_i = 23'h000040;
      tick();
      chk("ar_gnt",  32'(bus.gnt_o),   32'h1);
      chk("ar_mcyc", 32'(bus.m_cyc_o), 32'h1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("ar_mcyc_low", 32'(bus.m_cyc_o), 32'h0);
      chk("ar_mstb_low", 32'(bus.m_stb_o), 32'h0);
      chk("ar_madr_low", 32'(bus.m_adr_o), 32'h0);
      chk("ar_gnt_none", 32'(bus.gnt_o),   32'h0);
      bus.m_ack_i = 1'b1;
      #1;
      chk("ar_fack", 32'(bus.f_ack_o), 32'h0);
      tick();
      chk("ar_fack_edge", 32'(bus.f_ack_o), 32'h0);
      chk("ar_gnt_edge",  32'(bus.gnt_o),   32'h0);
      rst_n = 1'b1;
      bus.f_cyc_i = 1'b0;
      bus.m_ack_i = 1'b0;
      tick();
      chk("ar_post_gnt", 32'(bus.gnt_o), 32'h0);

      // Final report
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
